// File: rtl/disp_scan_reader_if.sv
// Pixel stream carried from disp_scan_reader to its consumer: valid/ready handshake
// plus pixel value, x/y coordinates and frame/line markers.
interface disp_scan_reader_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    logic          px_valid;
    logic          px_ready;
    logic          px_data;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic          px_sof;
    logic          px_eol;

    modport master (
        output px_valid,
        output px_data,
        output px_x,
        output px_y,
        output px_sof,
        output px_eol,
        input  px_ready
    );

    modport slave (
        input  px_valid,
        input  px_data,
        input  px_x,
        input  px_y,
        input  px_sof,
        input  px_eol,
        output px_ready
    );
endinterface

// File: rtl/disp_scan_reader.sv
// Row-major read-side scanner for the 1-bit framebuffer, streaming pixels on valid/ready.
// Optional inverse video when DISP_INVERT_EN is defined.
module disp_scan_reader #(
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int ADDR_W     = 10,
    parameter int GAP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cont,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rd_data,
    disp_scan_reader_if.master px,
    output logic               busy,
    output logic               frame_done
);
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic          data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
    } pix_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [ADDR_W-1:0] addr_q;

    logic              rd_vld_p1_q;
    logic [XW-1:0]     tag_x_p1_q;
    logic [YW-1:0]     tag_y_p1_q;
    logic              tag_sof_p1_q;
    logic              tag_eol_p1_q;

    pix_t              buf0_q, buf0_d;
    pix_t              buf1_q, buf1_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              head_vld;
    logic              pop;
    logic              push;
    logic              push_bit;
    logic [2:0]        credit;
    logic              issue;
    logic              last_pos;
    logic [ADDR_W-1:0] scan_addr;
    pix_t              new_px;

    assign head_vld = (cnt_q != 2'd0);
    assign pop      = head_vld && px.px_ready;
    assign push     = rd_vld_p1_q;

    // Reads in flight plus buffered pixels (after this cycle's pop) may never exceed two.
    assign credit    = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, rd_vld_p1_q};
    assign issue     = (state_q == S_SCAN) && (credit < 3'd2);
    assign last_pos  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign scan_addr = ADDR_W'(y_q) * ADDR_W'(WIDTH) + ADDR_W'(x_q);
    assign mem_addr  = issue ? scan_addr : addr_q;

`ifdef DISP_INVERT_EN
    assign push_bit = ~mem_rd_data;
`else
    assign push_bit = mem_rd_data;
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        gap_d      = gap_q;
        frame_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_SCAN: begin
                if (issue) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (last_pos) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (cnt_q == 2'd1) && !rd_vld_p1_q) begin
                    frame_done = 1'b1;
                    gap_d      = '0;
                    if (!cont) begin
                        state_d = S_IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == G_LAST) begin
                    gap_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = cont ? S_SCAN : S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry output FIFO; buf0 is always the head.
    always_comb begin
        new_px = '{data: push_bit, x: tag_x_p1_q, y: tag_y_p1_q,
                   sof: tag_sof_p1_q, eol: tag_eol_p1_q};
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    buf0_d = new_px;
                end else begin
                    buf1_d = new_px;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = new_px;
                end else begin
                    buf0_d = new_px;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            gap_q       <= '0;
            addr_q      <= '0;
            rd_vld_p1_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            gap_q       <= gap_d;
            addr_q      <= mem_addr;
            rd_vld_p1_q <= issue;
            cnt_q       <= cnt_d;
        end
    end

    // Read-return stage: tags follow the issued address by one cycle, like the memory data.
    always_ff @(posedge clk) begin
        tag_x_p1_q   <= x_q;
        tag_y_p1_q   <= y_q;
        tag_sof_p1_q <= (x_q == '0) && (y_q == '0);
        tag_eol_p1_q <= (x_q == X_LAST);
        buf0_q       <= buf0_d;
        buf1_q       <= buf1_d;
    end

    assign px.px_valid = head_vld;
    assign px.px_data  = head_vld & buf0_q.data;
    assign px.px_x     = head_vld ? buf0_q.x : '0;
    assign px.px_y     = head_vld ? buf0_q.y : '0;
    assign px.px_sof   = head_vld & buf0_q.sof;
    assign px.px_eol   = head_vld & buf0_q.eol;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_disp_scan_reader.sv
// Directed bench for disp_scan_reader: 32x32 framebuffer model with 1-cycle read latency.
module tb_disp_scan_reader;
    localparam int W    = 32;
    localparam int H    = 32;
    localparam int AW   = 10;
    localparam int GAP  = 4;
    localparam int NPIX = W * H;
`ifdef DISP_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cont;
    logic          mem_rd_data;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] mem_addr;
    logic          mem_model [0:NPIX-1];
    int            checks = 0;
    int            errors = 0;

    disp_scan_reader_if #(.XW(5), .YW(5)) px_if ();

    disp_scan_reader #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cont       (cont),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .px         (px_if),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rd_data <= mem_model[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives px_ready at the given duty and checks every transfer against the
    // framebuffer contents in row-major order; returns in the frame_done cycle,
    // or once stop_at pixels have been accepted.
    task automatic run_frame(input int duty, input int stop_at, input int drop_at,
                             output int n_xfer, output int n_fd, output int n_bub);
        int   idx       = 0;
        int   prev_addr = -1;
        bit   stalled   = 1'b0;
        bit   done      = 1'b0;
        bit   seen      = 1'b0;
        bit   xfer;
        logic [4:0] s_x, s_y;
        logic s_d, s_sof, s_eol;
        n_fd  = 0;
        n_bub = 0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            px_if.px_ready = ($urandom_range(0, 99) < duty);
            #1;
            if (int'(mem_addr) != prev_addr) begin
                chk("addr_lead", int'(mem_addr) <= idx + 2, 1);
                prev_addr = int'(mem_addr);
            end
            if (stalled) begin
                chk("stall_valid", px_if.px_valid, 1);
                chk("stall_x", px_if.px_x, s_x);
                chk("stall_y", px_if.px_y, s_y);
                chk("stall_data", px_if.px_data, s_d);
                chk("stall_sof", px_if.px_sof, s_sof);
                chk("stall_eol", px_if.px_eol, s_eol);
            end
            if (px_if.px_valid) seen = 1'b1;
            else if (seen) n_bub++;
            xfer = px_if.px_valid && px_if.px_ready;
            if (xfer) begin
                chk("px_x", px_if.px_x, idx % W);
                chk("px_y", px_if.px_y, idx / W);
                chk("px_data", px_if.px_data, mem_model[idx] ^ INV);
                chk("px_sof", px_if.px_sof, idx == 0);
                chk("px_eol", px_if.px_eol, (idx % W) == W - 1);
                idx++;
            end
            stalled = px_if.px_valid && !px_if.px_ready;
            s_x   = px_if.px_x;
            s_y   = px_if.px_y;
            s_d   = px_if.px_data;
            s_sof = px_if.px_sof;
            s_eol = px_if.px_eol;
            if (frame_done) begin
                n_fd++;
                chk("fd_last_pixel", xfer && (idx == NPIX), 1);
                done = 1'b1;
            end
            if (idx == drop_at) cont = 1'b0;
            if (idx == stop_at) done = 1'b1;
            if (!done) tick();
        end
        if (!done) chk("frame_timeout", 0, 1);
        n_xfer = idx;
    endtask

    initial begin
        int nx, nfd, nb, ngap;
        reset = 1'b1;
        start = 1'b0;
        cont  = 1'b0;
        px_if.px_ready = 1'b0;
        for (int a = 0; a < NPIX; a++) mem_model[a] = a[0] ^ a[5];
        tick();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", px_if.px_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_data", px_if.px_data, 0);
        chk("rst_x", px_if.px_x, 0);
        chk("rst_y", px_if.px_y, 0);
        chk("rst_sof", px_if.px_sof, 0);
        chk("rst_eol", px_if.px_eol, 0);

        // Single checkerboard frame at full rate
        px_if.px_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_c1_valid", px_if.px_valid, 0);
        chk("f1_busy", busy, 1);
        tick();
        chk("lat_c2_valid", px_if.px_valid, 0);
        tick();
        chk("lat_c3_valid", px_if.px_valid, 1);
        run_frame(100, -1, -1, nx, nfd, nb);
        chk("f1_count", nx, NPIX);
        chk("f1_fd", nfd, 1);
        chk("f1_bubbles", nb, 0);
        tick();
        chk("f1_busy_after", busy, 0);
        chk("f1_valid_after", px_if.px_valid, 0);

        // Random data, 30% ready duty
        for (int a = 0; a < NPIX; a++) mem_model[a] = 1'($urandom_range(0, 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(30, -1, -1, nx, nfd, nb);
        chk("f2_count", nx, NPIX);
        chk("f2_fd", nfd, 1);
        tick();
        chk("f2_busy_after", busy, 0);

        // start held high through SCAN, DRAIN and the frame_done cycle
        start = 1'b1;
        tick();
        run_frame(50, -1, -1, nx, nfd, nb);
        chk("f3_count", nx, NPIX);
        chk("f3_fd", nfd, 1);
        tick();
        start = 1'b0;
        chk("f3_busy_after", busy, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("f3_no_restart_valid", px_if.px_valid, 0);
            chk("f3_no_restart_busy", busy, 0);
        end

        // Continuous mode with gap, cont dropped mid second frame
        for (int a = 0; a < NPIX; a++) mem_model[a] = a[0] ^ a[5];
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(100, -1, -1, nx, nfd, nb);
        chk("c1_count", nx, NPIX);
        chk("c1_fd", nfd, 1);
        ngap = 0;
        tick();
        while (mem_addr != '0 && ngap < 50) begin
            chk("gap_busy", busy, 1);
            chk("gap_valid", px_if.px_valid, 0);
            ngap++;
            tick();
        end
        chk("gap_cycles", ngap, GAP);
        chk("c2_busy_c1", busy, 1);
        tick();
        tick();
        chk("c2_first_valid", px_if.px_valid, 1);
        chk("c2_first_sof", px_if.px_sof, 1);
        run_frame(100, -1, 500, nx, nfd, nb);
        chk("c2_count", nx, NPIX);
        chk("c2_fd", nfd, 1);
        tick();
        chk("c2_busy_after", busy, 0);
        tick();
        chk("c2_valid_after", px_if.px_valid, 0);
        chk("c2_idle_after", busy, 0);

        // Reset at pixel 500 while stalled, then restart from (0,0)
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(100, 500, -1, nx, nfd, nb);
        chk("r_count", nx, 500);
        chk("r_fd", nfd, 0);
        tick();
        px_if.px_ready = 1'b0;
        #1;
        chk("r_head_valid", px_if.px_valid, 1);
        chk("r_head_x", px_if.px_x, 20);
        chk("r_head_y", px_if.px_y, 15);
        chk("r_head_data", px_if.px_data, mem_model[500] ^ INV);
        tick();
        chk("r_hold_x", px_if.px_x, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_valid", px_if.px_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_addr", mem_addr, 0);
        chk("r_fd", frame_done, 0);
        px_if.px_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(100, -1, -1, nx, nfd, nb);
        chk("r2_count", nx, NPIX);
        chk("r2_fd", nfd, 1);
        tick();
        chk("r2_busy_after", busy, 0);

        // All-zero memory: output follows the inverse-video option
        for (int a = 0; a < NPIX; a++) mem_model[a] = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("z_first_data", px_if.px_data, INV);
        run_frame(100, -1, -1, nx, nfd, nb);
        chk("z_count", nx, NPIX);
        chk("z_fd", nfd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
